// File: rtl/bypass_rf_client.sv
// Initiator-side client for the bypass register file: reserve, read, write, free.
// Optional stall counters are enabled with `define BYPASS_RF_CLIENT_STATS_EN.
module bypass_rf_client #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int name_width = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [addr_width-1:0] REQ_RS1,
    input  logic [addr_width-1:0] REQ_RS2,
    input  logic [addr_width-1:0] REQ_RD,
    input  logic                  REQ_HAS_RD,
    output logic                  OP_VALID,
    input  logic                  OP_READY,
    output logic [data_width-1:0] OP_A,
    output logic [data_width-1:0] OP_B,
    output logic [name_width-1:0] OP_NAME,
    output logic                  OP_HAS_RD,
    input  logic                  WB_VALID,
    output logic                  WB_READY,
    input  logic [name_width-1:0] WB_NAME,
    input  logic [data_width-1:0] WB_DATA,
    output logic [addr_width-1:0] RF_ADDR_IN,
    output logic                  RF_ALLOC_E,
    input  logic                  RF_ALLOC_READY,
    input  logic [name_width-1:0] RF_NAME_OUT,
    output logic [addr_width-1:0] RF_ADDR_1,
    output logic [addr_width-1:0] RF_ADDR_2,
    output logic                  RF_RRESE_1,
    output logic                  RF_RRESE_2,
    input  logic                  RF_RRES_READY_1,
    input  logic                  RF_RRES_READY_2,
    input  logic [name_width-1:0] RF_RNAME_1,
    input  logic [name_width-1:0] RF_RNAME_2,
    output logic [name_width-1:0] RF_NAME_1,
    output logic [name_width-1:0] RF_NAME_2,
    input  logic [data_width-1:0] RF_D_OUT_1,
    input  logic [data_width-1:0] RF_D_OUT_2,
    input  logic                  RF_VALID_1,
    input  logic                  RF_VALID_2,
    output logic                  RF_FE_1,
    output logic                  RF_FE_2,
    output logic [name_width-1:0] RF_RD_F_1,
    output logic [name_width-1:0] RF_RD_F_2,
    output logic                  RF_WE,
    output logic [name_width-1:0] RF_NAME_IN,
    output logic [data_width-1:0] RF_D_IN,
    output logic                  RF_WFE,
    output logic [name_width-1:0] RF_W_F,
    input  logic                  RF_F_READY
`ifdef BYPASS_RF_CLIENT_STATS_EN
    ,
    output logic [15:0]           STALL_RES_CNT,
    output logic [15:0]           STALL_WAIT_CNT
`endif
);

    localparam int NUM_NAMES = 2 ** name_width;

    typedef logic [name_width-1:0] name_t;
    typedef enum logic [1:0] {S_IDLE, S_RES, S_WAIT, S_PRESENT} state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                  has_rd_q, has_rd_d;
    name_t                 rname1_q, rname1_d, rname2_q, rname2_d;
    logic [data_width-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    name_t                 op_name_q, op_name_d;
    logic [NUM_NAMES-1:0]  live_q, live_d, written_q, written_d;
    name_t                 free_ptr_q, free_ptr_d;
    logic                  res_fire, wait_fire, wb_fire;

    assign res_fire  = RF_RRES_READY_1 & RF_RRES_READY_2 &
                       (RF_ALLOC_READY | ~has_rd_q);
    assign wait_fire = RF_VALID_1 & RF_VALID_2;

    assign REQ_READY  = (state_q == S_IDLE) & RST;
    assign OP_VALID   = (state_q == S_PRESENT);
    assign OP_A       = op_a_q;
    assign OP_B       = op_b_q;
    assign OP_NAME    = op_name_q;
    assign OP_HAS_RD  = has_rd_q;
    assign RF_ADDR_1  = rs1_q;
    assign RF_ADDR_2  = rs2_q;
    assign RF_ADDR_IN = rd_q;
    assign RF_NAME_1  = rname1_q;
    assign RF_NAME_2  = rname2_q;
    assign RF_RD_F_1  = rname1_q;
    assign RF_RD_F_2  = rname2_q;

    assign WB_READY   = live_q[WB_NAME] & ~written_q[WB_NAME];
    assign wb_fire    = WB_VALID & WB_READY;
    assign RF_WE      = wb_fire;
    assign RF_NAME_IN = WB_NAME;
    assign RF_D_IN    = WB_DATA;
    assign RF_W_F     = free_ptr_q;
    assign RF_WFE     = live_q[free_ptr_q] & written_q[free_ptr_q] & RF_F_READY;

    // Read FSM next state, atomic reservations and operand capture
    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        has_rd_d   = has_rd_q;
        rname1_d   = rname1_q;
        rname2_d   = rname2_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_name_d  = op_name_q;
        RF_RRESE_1 = 1'b0;
        RF_RRESE_2 = 1'b0;
        RF_ALLOC_E = 1'b0;
        RF_FE_1    = 1'b0;
        RF_FE_2    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    rs1_d    = REQ_RS1;
                    rs2_d    = REQ_RS2;
                    rd_d     = REQ_RD;
                    has_rd_d = REQ_HAS_RD;
                    state_d  = S_RES;
                end
            end
            S_RES: begin
                if (res_fire) begin
                    RF_RRESE_1 = 1'b1;
                    RF_RRESE_2 = 1'b1;
                    RF_ALLOC_E = has_rd_q;
                    rname1_d   = RF_RNAME_1;
                    rname2_d   = RF_RNAME_2;
                    op_name_d  = has_rd_q ? RF_NAME_OUT : '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_fire) begin
                    op_a_d  = RF_D_OUT_1;
                    op_b_d  = RF_D_OUT_2;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (OP_READY) begin
                    RF_FE_1 = 1'b1;
                    RF_FE_2 = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-name tracking: allocate, mark written, free in allocation order
    always_comb begin
        live_d     = live_q;
        written_d  = written_q;
        free_ptr_d = free_ptr_q;
        if (RF_ALLOC_E) begin
            live_d[RF_NAME_OUT] = 1'b1;
        end
        if (wb_fire) begin
            written_d[WB_NAME] = 1'b1;
        end
        if (RF_WFE) begin
            live_d[free_ptr_q]    = 1'b0;
            written_d[free_ptr_q] = 1'b0;
            free_ptr_d            = free_ptr_q + name_t'(1);
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            has_rd_q   <= 1'b0;
            rname1_q   <= '0;
            rname2_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_name_q  <= '0;
            live_q     <= '0;
            written_q  <= '0;
            free_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            has_rd_q   <= has_rd_d;
            rname1_q   <= rname1_d;
            rname2_q   <= rname2_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_name_q  <= op_name_d;
            live_q     <= live_d;
            written_q  <= written_d;
            free_ptr_q <= free_ptr_d;
        end
    end

`ifdef BYPASS_RF_CLIENT_STATS_EN
    logic [15:0] stall_res_q, stall_res_d, stall_wait_q, stall_wait_d;

    assign STALL_RES_CNT  = stall_res_q;
    assign STALL_WAIT_CNT = stall_wait_q;

    // Saturating stall counters for blocked reservation and operand wait
    always_comb begin
        stall_res_d  = stall_res_q;
        stall_wait_d = stall_wait_q;
        if (state_q == S_RES && !res_fire && stall_res_q != 16'hFFFF) begin
            stall_res_d = stall_res_q + 16'd1;
        end
        if (state_q == S_WAIT && !wait_fire && stall_wait_q != 16'hFFFF) begin
            stall_wait_d = stall_wait_q + 16'd1;
        end
    end

    // Stall counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_res_q  <= '0;
            stall_wait_q <= '0;
        end else begin
            stall_res_q  <= stall_res_d;
            stall_wait_q <= stall_wait_d;
        end
    end
`endif

endmodule

// File: doc/bypass_rf_client.md
Name: bypass_rf_client

Overview:
- Initiator-side controller for the bypass register file's reservation/read/write/free protocol.
- Sits in one pipeline stage and accepts one instruction descriptor at a time (rs1, rs2, optional rd).
- Reserves both read operands and the rd write name, waits until the operands are valid, then presents them downstream.
- Separately accepts writebacks and frees write names in allocation order.

Parameters:
- addr_width, 5, architectural register address width
- data_width, 32, operand/data width
- name_width, 2, RF name width; numNames = 2**name_width

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- REQ_VALID/REQ_READY  in/out  1  descriptor handshake
- REQ_RS1, REQ_RS2, REQ_RD  in  addr_width  source/destination addresses
- REQ_HAS_RD  in  1  instruction writes rd
- OP_VALID/OP_READY  out/in  1  operand handshake
- OP_A, OP_B  out  data_width  operand values
- OP_NAME  out  name_width  write name allocated for rd (0 if !has_rd)
- OP_HAS_RD  out  1  copy of REQ_HAS_RD
- WB_VALID/WB_READY  in/out  1  writeback handshake
- WB_NAME  in  name_width  name being written
- WB_DATA  in  data_width  value being written
- RF_ADDR_IN  out  addr_width  to ADDR_IN
- RF_ALLOC_E  out  1  to ALLOC_E
- RF_ALLOC_READY  in  1  from ALLOC_READY
- RF_NAME_OUT  in  name_width  from NAME_OUT
- RF_ADDR_1/2  out  addr_width  to ADDR_1/2
- RF_RRESE_1/2  out  1  to RRESE_1/2
- RF_RRES_READY_1/2  in  1  from RRES_READY_1/2
- RF_RNAME_1/2  in  name_width  from RNAME_OUT_1/2
- RF_NAME_1/2  out  name_width  to NAME_1/2 and VALID_NAME_1/2
- RF_D_OUT_1/2  in  data_width  from D_OUT_1/2
- RF_VALID_1/2  in  1  from VALID_OUT_1/2
- RF_FE_1/2  out  1  to FE_1/2
- RF_RD_F_1/2  out  name_width  to RD_F_1/2
- RF_WE  out  1  to WE_1
- RF_NAME_IN  out  name_width  to NAME_IN_1
- RF_D_IN  out  data_width  to D_IN_1
- RF_WFE  out  1  to WFE
- RF_W_F  out  name_width  to W_F
- RF_F_READY  in  1  from F_READY

Behaviour:

Read FSM states: IDLE, RES, WAIT, PRESENT.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, latch rs1/rs2/rd/has_rd; go to RES.
- RES:
  - Drives RF_ADDR_1=rs1, RF_ADDR_2=rs2, RF_ADDR_IN=rd.
  - Fires only when RF_RRES_READY_1 & RF_RRES_READY_2 & (RF_ALLOC_READY | !has_rd). All reservations are atomic in one cycle: RRESE_1, RRESE_2 and ALLOC_E (if has_rd) are asserted together, never partially.
  - Read reservations see the pre-allocation write queue, so rs==rd yields the older writer.
  - On fire, latch RNAME_1/2 and (if has_rd) RF_NAME_OUT into OP_NAME; go to WAIT.
- WAIT:
  - RF_NAME_1/2 = latched read names.
  - When RF_VALID_1 & RF_VALID_2 in the same cycle, register D_OUT_1→OP_A and D_OUT_2→OP_B; go to PRESENT.
  - Partial validity is not latched.
- PRESENT:
  - OP_VALID=1; OP_A/OP_B held stable.
  - On OP_READY, assert RF_FE_1 (RD_F_1=rname1) and RF_FE_2 (RD_F_2=rname2) for that cycle only; go to IDLE.
- Minimum latency: REQ accepted cycle 0, reservations cycle 1, operands latched cycle 2, OP_VALID cycle 3.
- Throughput: one instruction per 4 cycles, no overlap.

Write side (independent of the read FSM):
- live[n] is set on allocation; written[n] is set on writeback; free_ptr is name_width bits.
- WB_READY = live[WB_NAME] & !written[WB_NAME].
- On WB handshake, RF_WE=1, RF_NAME_IN=WB_NAME, RF_D_IN=WB_DATA in the same cycle (combinational); set written[WB_NAME].
- A WB to a name that is not live, or already written, stalls indefinitely. This is a bench assertion.
- RF_W_F=free_ptr; RF_WFE = live[free_ptr] & written[free_ptr] & RF_F_READY.
- On free, clear live and written for that name; free_ptr+1, wrapping mod numNames.
- Frees are strictly in allocation order even if writebacks arrive out of order.
- Alloc and free of the same name in one cycle cannot occur: ALLOC_READY is low while the entry is valid.

Reset (asynchronous, RST=0):
- State IDLE; OP_VALID=0; OP_A/OP_B/OP_NAME=0.
- live and written cleared; free_ptr=0.
- All RF enables low; REQ_READY=0 while reset is asserted.
- Reset mid-operation abandons reservations; the RF must be reset with the same reset.

Optional Feature:
BYPASS_RF_CLIENT_STATS_EN
- Defined: adds 16-bit outputs STALL_RES_CNT and STALL_WAIT_CNT.
  - They count cycles spent in RES without firing and in WAIT without both operands valid.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; functionality is otherwise identical.

Test Plan:
- No conflicts: REQ rs1=3, rs2=4, rd=5, has_rd with RF regs 3=0x11, 4=0x22 → OP_VALID at cycle 3 with OP_A=0x11, OP_B=0x22, OP_NAME=0; FE_1/FE_2 pulse on OP_READY.
- RAW: instr A writes r5 (name 0, not yet written); instr B reads r5 → B stays in WAIT; WB name 0 data 0x99 → B's OP_A=0x99 next cycle.
- rs==rd: instr reads and writes r7 (old value 0x7) → OP_A=0x7, not its own pending write.
- Out-of-order writeback: allocate names 0 and 1; WB name 1 first → no WFE; WB name 0 → WFE on W_F=0, then W_F=1 on consecutive cycles.
- RF full: 4 names live and unwritten; new has_rd instr stays in RES (no RRESE pulse) until the first free completes; ALLOC fires the cycle after.
- Reset asserted asynchronously while in PRESENT → OP_VALID drops immediately; after release REQ_READY=1 and free_ptr=0.
